// File: rtl/hazard_stall_unit_pkg.sv
// Shared pipeline definitions for the hazard/stall control block.
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        StRun,
        StMemWait,
        StFlush
    } hz_state_e;

    localparam logic [4:0]  REG_ZERO = 5'd0;
    // addi x0, x0, 0 -- what a bubbled stage register carries
    localparam logic [31:0] NOP      = 32'h0000_0013;

    function automatic logic load_use_hit(
        input logic       mem_read,
        input logic [4:0] rd,
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs2
    );
        return mem_read && (rd != REG_ZERO) && ((rd == rs1) || (uses_rs2 && (rd == rs2)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_if.sv
// Pipeline-to-hazard-unit signal bundle; master is the pipeline side, slave the hazard unit.
interface hazard_stall_unit_if #(
    parameter int unsigned CNT_W = 32
);

    logic [4:0]       Rs1_IF_ID;
    logic [4:0]       Rs2_IF_ID;
    logic             uses_rs2_IF_ID;
    logic [4:0]       Rd_ID_EXE;
    logic             mem_read_ID_EXE;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ack;

    logic             pc_write;
    logic             if_id_write;
    logic             id_exe_write;
    logic             exe_mem_write;
    logic             id_exe_bubble;
    logic             mem_wb_bubble;
    logic             if_id_flush;
    logic             id_exe_flush;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_cycles;
    logic             err_timeout;

    modport master (
        output Rs1_IF_ID, Rs2_IF_ID, uses_rs2_IF_ID, Rd_ID_EXE, mem_read_ID_EXE,
               branch_taken, dmem_req, dmem_ack,
        input  pc_write, if_id_write, id_exe_write, exe_mem_write, id_exe_bubble,
               mem_wb_bubble, if_id_flush, id_exe_flush, stall_cycles, flush_cycles,
               err_timeout
    );

    modport slave (
        input  Rs1_IF_ID, Rs2_IF_ID, uses_rs2_IF_ID, Rd_ID_EXE, mem_read_ID_EXE,
               branch_taken, dmem_req, dmem_ack,
        output pc_write, if_id_write, id_exe_write, exe_mem_write, id_exe_bubble,
               mem_wb_bubble, if_id_flush, id_exe_flush, stall_cycles, flush_cycles,
               err_timeout
    );

endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble/flush control for the 5-stage pipeline: load-use, dmem waits, branch flush.
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int unsigned BRANCH_PENALTY = 2,
    parameter int unsigned MEM_TIMEOUT    = 64,
    parameter int unsigned CNT_W          = 32
) (
    input  logic                clk,
    input  logic                arst,
    hazard_stall_unit_if.slave  hz
);

    localparam int unsigned       WaitW     = $clog2(MEM_TIMEOUT);
    localparam logic [WaitW-1:0]  WaitLast  = WaitW'(MEM_TIMEOUT - 1);
    localparam logic [2:0]        FlushInit = 3'(BRANCH_PENALTY - 1);

    hz_state_e        state_q, state_d;
    logic [2:0]       flush_cnt_q, flush_cnt_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic             err_q, err_d;

    logic mem_wait;
    logic load_use;

    assign mem_wait = hz.dmem_req && !hz.dmem_ack;
    assign load_use = load_use_hit(hz.mem_read_ID_EXE, hz.Rd_ID_EXE, hz.Rs1_IF_ID,
                                   hz.Rs2_IF_ID, hz.uses_rs2_IF_ID);

    always_comb begin
        hz.pc_write      = 1'b1;
        hz.if_id_write   = 1'b1;
        hz.id_exe_write  = 1'b1;
        hz.exe_mem_write = 1'b1;
        hz.id_exe_bubble = 1'b0;
        hz.mem_wb_bubble = 1'b0;
        hz.if_id_flush   = 1'b0;
        hz.id_exe_flush  = 1'b0;
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        wait_cnt_d       = '0;
        err_d            = err_q;

        if (mem_wait) begin
            // Whole pipe frozen; a pending flush keeps its remaining count.
            hz.pc_write      = 1'b0;
            hz.if_id_write   = 1'b0;
            hz.id_exe_write  = 1'b0;
            hz.exe_mem_write = 1'b0;
            hz.mem_wb_bubble = 1'b1;
            state_d          = StMemWait;
            if (wait_cnt_q == WaitLast) begin
                err_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + WaitW'(1);
            end
        end else if (hz.branch_taken) begin
            hz.if_id_flush  = 1'b1;
            hz.id_exe_flush = 1'b1;
            flush_cnt_d     = FlushInit;
            state_d         = (FlushInit != 3'd0) ? StFlush : StRun;
        end else begin
            unique case (state_q)
                StMemWait: begin
                    state_d = (flush_cnt_q != 3'd0) ? StFlush : StRun;
                end
                StFlush: begin
                    hz.if_id_flush  = 1'b1;
                    hz.id_exe_flush = 1'b1;
                    flush_cnt_d     = flush_cnt_q - 3'd1;
                    if (flush_cnt_q <= 3'd1) begin
                        flush_cnt_d = 3'd0;
                        state_d     = StRun;
                    end
                end
                StRun: begin
                    if (load_use) begin
                        hz.pc_write      = 1'b0;
                        hz.if_id_write   = 1'b0;
                        hz.id_exe_bubble = 1'b1;
                    end
                end
                default: begin
                    state_d     = StRun;
                    flush_cnt_d = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= StRun;
            flush_cnt_q <= 3'd0;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
        end
    end

    assign hz.err_timeout = err_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (!hz.pc_write),
        .count (hz.stall_cycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .arst  (arst),
        .inc   (hz.if_id_flush),
        .count (hz.flush_cycles)
    );

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized bench for hazard_stall_unit against a cycle-level behavioural model.
module tb_hazard_stall_unit;

    localparam int unsigned BP = 2;
    localparam int unsigned TO = 64;
    localparam int unsigned CW = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    // {pc_write, if_id_write, id_exe_write, exe_mem_write,
    //  id_exe_bubble, mem_wb_bubble, if_id_flush, id_exe_flush}
    localparam logic [7:0] OUT_DEF    = 8'b1111_0000;
    localparam logic [7:0] OUT_FREEZE = 8'b0000_0100;
    localparam logic [7:0] OUT_FLUSH  = 8'b1111_0011;
    localparam logic [7:0] OUT_LU     = 8'b0011_1000;

    logic clk = 1'b0;
    logic arst;
    always #5 clk = ~clk;

    hazard_stall_unit_if #(.CNT_W(CW)) hz ();

    hazard_stall_unit #(
        .BRANCH_PENALTY (BP),
        .MEM_TIMEOUT    (TO),
        .CNT_W          (CW)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .hz   (hz)
    );

    int checks = 0;
    int errors = 0;

    // Model: owed flush cycles, whether last cycle was a memory freeze, run length of waits.
    int flush_rem;
    bit prev_wait;
    int wait_run;
    bit m_err;
    int m_stall;
    int m_flush;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] dut_outs();
        return {hz.pc_write, hz.if_id_write, hz.id_exe_write, hz.exe_mem_write,
                hz.id_exe_bubble, hz.mem_wb_bubble, hz.if_id_flush, hz.id_exe_flush};
    endfunction

    function automatic int sat(input int v);
        return (v > int'(CNT_MAX)) ? int'(CNT_MAX) : v;
    endfunction

    task automatic model_reset();
        flush_rem = 0;
        prev_wait = 1'b0;
        wait_run  = 0;
        m_err     = 1'b0;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    task automatic set_idle();
        hz.Rs1_IF_ID       = 5'd0;
        hz.Rs2_IF_ID       = 5'd0;
        hz.uses_rs2_IF_ID  = 1'b0;
        hz.Rd_ID_EXE       = 5'd0;
        hz.mem_read_ID_EXE = 1'b0;
        hz.branch_taken    = 1'b0;
        hz.dmem_req        = 1'b0;
        hz.dmem_ack        = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, "_stall"}, 32'(hz.stall_cycles), 32'(sat(m_stall)));
        check_eq({tag, "_flush"}, 32'(hz.flush_cycles), 32'(sat(m_flush)));
        check_eq({tag, "_err"}, 32'(hz.err_timeout), 32'(m_err));
    endtask

    // Inputs were applied at the preceding negedge; check, then advance the model past the edge.
    task automatic check_and_step(input string tag);
        logic [7:0] exp;
        bit mw;
        bit lu;
        #1;
        mw = hz.dmem_req && !hz.dmem_ack;
        lu = hz.mem_read_ID_EXE && (hz.Rd_ID_EXE != 5'd0) &&
             ((hz.Rd_ID_EXE == hz.Rs1_IF_ID) ||
              (hz.uses_rs2_IF_ID && (hz.Rd_ID_EXE == hz.Rs2_IF_ID)));
        if (mw) begin
            exp = OUT_FREEZE;
        end else if (hz.branch_taken) begin
            exp = OUT_FLUSH;
        end else if (prev_wait) begin
            exp = OUT_DEF;
        end else if (flush_rem > 0) begin
            exp = OUT_FLUSH;
        end else if (lu) begin
            exp = OUT_LU;
        end else begin
            exp = OUT_DEF;
        end
        check_eq({tag, "_outs"}, 32'(dut_outs()), 32'(exp));
        check_regs(tag);

        if (mw) begin
            wait_run++;
            if (wait_run >= int'(TO)) m_err = 1'b1;
            prev_wait = 1'b1;
        end else begin
            wait_run = 0;
            if (hz.branch_taken) begin
                flush_rem = BP - 1;
            end else if (!prev_wait && flush_rem > 0) begin
                flush_rem--;
            end
            prev_wait = 1'b0;
        end
        if (!exp[7]) m_stall++;
        if (exp[1]) m_flush++;
    endtask

    initial begin
        bit in_txn;

        arst = 1'b1;
        set_idle();
        model_reset();
        #1;
        check_eq("rst_outs", 32'(dut_outs()), 32'(OUT_DEF));
        check_regs("rst");
        @(negedge clk);
        arst = 1'b0;

        // Directed: load-use on rs1, then x0 and rs2-without-use cases.
        hz.mem_read_ID_EXE = 1'b1;
        hz.Rd_ID_EXE = 5'd5;
        hz.Rs1_IF_ID = 5'd5;
        check_and_step("lu_rs1");
        @(negedge clk);
        set_idle();
        check_and_step("lu_clear");
        @(negedge clk);
        hz.mem_read_ID_EXE = 1'b1;
        check_and_step("lu_x0");
        @(negedge clk);
        hz.Rd_ID_EXE = 5'd7;
        hz.Rs1_IF_ID = 5'd1;
        hz.Rs2_IF_ID = 5'd7;
        check_and_step("lu_rs2_unused");
        @(negedge clk);
        set_idle();

        // Directed: dmem wait with ack after three cycles, branch held across it.
        hz.dmem_req = 1'b1;
        hz.branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_and_step("wait_br");
            @(negedge clk);
        end
        hz.dmem_ack = 1'b1;
        check_and_step("ack_br");
        @(negedge clk);
        set_idle();
        hz.mem_read_ID_EXE = 1'b1;
        hz.Rd_ID_EXE = 5'd3;
        hz.Rs1_IF_ID = 5'd3;
        check_and_step("flush_lu");
        @(negedge clk);
        set_idle();
        check_and_step("post_flush");

        // Randomized traffic.
        in_txn = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            hz.Rs1_IF_ID       = 5'($urandom_range(0, 3));
            hz.Rs2_IF_ID       = 5'($urandom_range(0, 3));
            hz.uses_rs2_IF_ID  = 1'($urandom_range(0, 1));
            hz.Rd_ID_EXE       = 5'($urandom_range(0, 3));
            hz.mem_read_ID_EXE = 1'($urandom_range(0, 1));
            hz.branch_taken    = ($urandom_range(0, 9) == 0);
            if (!in_txn) in_txn = ($urandom_range(0, 4) == 0);
            hz.dmem_req = in_txn;
            hz.dmem_ack = in_txn && ($urandom_range(0, 4) < 2);
            if (hz.dmem_ack) in_txn = 1'b0;
            check_and_step("rand");
        end

        // Timeout: clean start, hold the request unacknowledged past the limit.
        @(negedge clk);
        set_idle();
        arst = 1'b1;
        model_reset();
        @(negedge clk);
        arst = 1'b0;
        hz.dmem_req = 1'b1;
        for (int i = 0; i < int'(TO) + 4; i++) begin
            check_and_step("timeout");
            @(negedge clk);
        end
        hz.dmem_ack = 1'b1;
        check_and_step("to_ack");
        @(negedge clk);
        set_idle();
        check_and_step("to_idle");
        check_eq("err_sticky", 32'(hz.err_timeout), 32'd1);

        // Branch into FLUSH, then reset in the middle of the flush cycle.
        @(negedge clk);
        hz.branch_taken = 1'b1;
        check_and_step("br_enter");
        @(negedge clk);
        set_idle();
        #1;
        check_eq("in_flush", 32'(dut_outs()), 32'(OUT_FLUSH));
        arst = 1'b1;
        model_reset();
        #1;
        check_eq("arst_flush_outs", 32'(dut_outs()), 32'(OUT_DEF));
        check_regs("arst_flush");
        @(negedge clk);
        arst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_and_step("after_rst");
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
